// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary to packed-BCD converter (shift-add-3 / double dabble).
//   One add-3 + shift iteration per clock, BIN_W iterations per conversion.
//   Optional two's-complement input: the magnitude is converted and the sign
//   is reported on NEG. Results that do not fit in DIGITS decimal digits
//   saturate to all 9s and raise OVF.
//
// Ports
//   CLK     in   system clock
//   RST     in   synchronous reset, active-high
//   START   in   conversion request, sampled only while idle
//   BIN     in   binary value [BIN_W-1:0], sampled on the accepting edge
//   BUSY    out  high while a conversion is in progress
//   DONE    out  one-cycle pulse, BCDOUT/NEG/OVF freshly updated
//   BCDOUT  out  packed BCD result [4*DIGITS-1:0], ones digit at [3:0]
//   NEG     out  sign of the last result (always 0 when SIGNED=0)
//   OVF     out  last result exceeded 10^DIGITS-1
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCDOUT,
    output logic                  NEG,
    output logic                  OVF
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // {bcd field, binary field}; the binary field drains into the bcd field.
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_sticky;
    logic               r_sign;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_bcd_sat;
    logic [SR_W-1:0]    w_sr_shift;
    logic               w_shift_out;
    logic               w_neg_in;
    logic [BIN_W-1:0]   w_mag;
    logic               w_last;

    // Per-digit add-3 correction; digits are independent 4-bit adds.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_bcd_adj[4*gi +: 4] = (r_sr[BIN_W + 4*gi +: 4] >= 4'd5)
                                        ? r_sr[BIN_W + 4*gi +: 4] + 4'd3
                                        : r_sr[BIN_W + 4*gi +: 4];
            assign w_bcd_sat[4*gi +: 4] = 4'h9;
        end
    endgenerate

    // The MSB of the corrected top digit leaves the register on the shift;
    // any such bit means the value has reached 10^DIGITS.
    assign w_shift_out = w_bcd_adj[BCD_W-1];
    assign w_sr_shift  = {w_bcd_adj[BCD_W-2:0], r_sr[BIN_W-1:0], 1'b0};

    // Negation in BIN_W bits: the most negative input maps to 2^(BIN_W-1),
    // which is the right magnitude when read as unsigned.
    assign w_neg_in = (SIGNED != 0) && BIN[BIN_W-1];
    assign w_mag    = w_neg_in ? -BIN : BIN;

    assign w_last   = (r_cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (START) w_state_next = S_CONV;
            S_CONV:  if (w_last) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sr         <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_sign       <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            BCDOUT       <= '0;
            NEG          <= 1'b0;
            OVF          <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_sr         <= {{BCD_W{1'b0}}, w_mag};
                        r_cnt        <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_sign       <= w_neg_in;
                        BUSY         <= 1'b1;
                    end
                end
                S_CONV: begin
                    r_sr         <= w_sr_shift;
                    r_cnt        <= r_cnt + CNT_W'(1);
                    r_ovf_sticky <= r_ovf_sticky | w_shift_out;
                end
                S_FIN: begin
                    BCDOUT <= r_ovf_sticky ? w_bcd_sat : r_sr[SR_W-1:BIN_W];
                    OVF    <= r_ovf_sticky;
                    NEG    <= r_sign;
                    DONE   <= 1'b1;
                    BUSY   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
